arbitro_pop: RTL and testbench

//  Pop/arbitration control stage directly upstream of the VC-to-D routing mux.

---
 rtl/arbitro_pop.sv | 157 +++++++++++++++
 tb/tb_arbitro_pop.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/arbitro_pop.sv
// ----------------------------------------------------------------------------
// arbitro_pop
//   Pop/arbitration control for the two virtual-channel FIFOs feeding the
//   VC-to-D routing mux. VC0 has strict priority. After MAX_CONSEC back-to-back
//   VC0 pops while VC1 is waiting, one VC1 pop is forced. Pops are blocked
//   while either destination FIFO is almost full. The registered pop_delay_*
//   outputs line up with the FIFO read latency and mark mux data valid. A D
//   FIFO that is full while read data is arriving is an overflow. An overflow
//   latches a sticky ERROR state that only reset_L clears.
//
// Ports
//   clk, reset_L          clock (rising edge), async active-low reset
//   init                  hold in INIT: clears counters, blocks pops
//   VC0_empty, VC1_empty  source FIFO empty flags
//   D0/D1_almost_full     destination backpressure (gates all pops)
//   D0/D1_full            destination full (overflow detection)
//   pop_VC0, pop_VC1      combinational pop strobes to the VC FIFOs
//   pop_delay_VC0/VC1     pop strobes delayed one cycle (read data valid)
//   state                 RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4
//   idle_out, error_out   state decodes
//   cnt_VC0, cnt_VC1      pops per VC since last INIT (wrapping)
// ----------------------------------------------------------------------------
module arbitro_pop #(
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic             VC0_empty,
    input  logic             VC1_empty,
    input  logic             D0_almost_full,
    input  logic             D1_almost_full,
    input  logic             D0_full,
    input  logic             D1_full,
    output logic             pop_VC0,
    output logic             pop_VC1,
    output logic             pop_delay_VC0,
    output logic             pop_delay_VC1,
    output logic [2:0]       state,
    output logic             idle_out,
    output logic             error_out,
    output logic [CNT_W-1:0] cnt_VC0,
    output logic [CNT_W-1:0] cnt_VC1
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int unsigned CONSEC_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_CONSEC);

    state_t              cur_state;
    state_t              nxt_state;
    logic [CONSEC_W-1:0] consec;
    logic                overflow;
    logic                go;
    logic                force1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cur_state <= ST_RESET;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and pop decisions
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        overflow  = (pop_delay_VC0 | pop_delay_VC1) & (D0_full | D1_full);
        go        = ((cur_state == ST_IDLE) || (cur_state == ST_ACTIVE))
                    & ~init & ~D0_almost_full & ~D1_almost_full;
        force1    = (consec == CONSEC_MAX) & ~VC1_empty;
        pop_VC0   = go & ~VC0_empty & ~force1;
        pop_VC1   = go & ~VC1_empty & ~pop_VC0;

        // Overflow outranks init in every non-RESET state.
        case (cur_state)
            ST_RESET: nxt_state = ST_INIT;
            ST_INIT: begin
                if (overflow)   nxt_state = ST_ERROR;
                else if (!init) nxt_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (overflow)                      nxt_state = ST_ERROR;
                else if (init)                     nxt_state = ST_INIT;
                else if (!VC0_empty || !VC1_empty) nxt_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (overflow)                     nxt_state = ST_ERROR;
                else if (init)                    nxt_state = ST_INIT;
                else if (VC0_empty && VC1_empty)  nxt_state = ST_IDLE;
            end
            ST_ERROR: nxt_state = ST_ERROR;
            default:  nxt_state = ST_RESET;
        endcase
    end

    // ------------------------------------------------------------------
    // Delayed pop qualifiers. A pop issued on the edge that enters ERROR
    // is not flagged valid, so pop_delay_* stays low throughout ERROR.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_delay_VC0 <= 1'b0;
            pop_delay_VC1 <= 1'b0;
        end else begin
            pop_delay_VC0 <= pop_VC0 & ~overflow;
            pop_delay_VC1 <= pop_VC1 & ~overflow;
        end
    end

    // ------------------------------------------------------------------
    // Anti-starvation run length of VC0 pops while VC1 is waiting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            consec <= '0;
        end else if (cur_state == ST_INIT || pop_VC1 || VC1_empty) begin
            consec <= '0;
        end else if (pop_VC0 && consec != CONSEC_MAX) begin
            consec <= consec + CONSEC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-VC pop counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_VC0 <= '0;
            cnt_VC1 <= '0;
        end else if (cur_state == ST_INIT) begin
            cnt_VC0 <= '0;
            cnt_VC1 <= '0;
        end else if (cur_state != ST_ERROR) begin
            if (pop_VC0) cnt_VC0 <= cnt_VC0 + CNT_W'(1);
            if (pop_VC1) cnt_VC1 <= cnt_VC1 + CNT_W'(1);
        end
    end

    assign state     = cur_state;
    assign idle_out  = (cur_state == ST_IDLE);
    assign error_out = (cur_state == ST_ERROR);

endmodule

// File: tb/tb_arbitro_pop.sv
module tb_arbitro_pop;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic       VC0_empty, VC1_empty;
    logic       D0_almost_full, D1_almost_full;
    logic       D0_full, D1_full;
    logic       pop_VC0, pop_VC1;
    logic       pop_delay_VC0, pop_delay_VC1;
    logic [2:0] state;
    logic       idle_out, error_out;
    logic [7:0] cnt_VC0, cnt_VC1;

    int n_tests = 0;
    int n_fail  = 0;

    arbitro_pop #(.MAX_CONSEC(4), .CNT_W(8)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .VC0_empty      (VC0_empty),
        .VC1_empty      (VC1_empty),
        .D0_almost_full (D0_almost_full),
        .D1_almost_full (D1_almost_full),
        .D0_full        (D0_full),
        .D1_full        (D1_full),
        .pop_VC0        (pop_VC0),
        .pop_VC1        (pop_VC1),
        .pop_delay_VC0  (pop_delay_VC0),
        .pop_delay_VC1  (pop_delay_VC1),
        .state          (state),
        .idle_out       (idle_out),
        .error_out      (error_out),
        .cnt_VC0        (cnt_VC0),
        .cnt_VC1        (cnt_VC1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       init, v0e, v1e, af0, af1, f0, f1;
        logic       p0, p1, pd0, pd1;
        logic [2:0] st;
        logic [7:0] c0, c1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic i, v0e, v1e, af0, af1, f0, f1,
                       input logic p0, p1, pd0, pd1,
                       input int st, c0, c1);
        vec_t v;
        v.init = i;  v.v0e = v0e; v.v1e = v1e;
        v.af0 = af0; v.af1 = af1; v.f0 = f0; v.f1 = f1;
        v.p0 = p0;   v.p1 = p1;   v.pd0 = pd0; v.pd1 = pd1;
        v.st = 3'(st); v.c0 = 8'(c0); v.c1 = 8'(c1);
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b1;
        VC0_empty = 1'b1; VC1_empty = 1'b1;
        D0_almost_full = 1'b0; D1_almost_full = 1'b0;
        D0_full = 1'b0; D1_full = 1'b0;

        //   init v0e v1e af0 af1 f0 f1 | p0 p1 pd0 pd1 st c0 c1
        add(1,1,1,0,0,0,0, 0,0,0,0, 0, 0,0);   // RESET
        add(1,1,1,0,0,0,0, 0,0,0,0, 1, 0,0);   // INIT held
        add(1,1,1,0,0,0,0, 0,0,0,0, 1, 0,0);
        add(0,1,1,0,0,0,0, 0,0,0,0, 1, 0,0);   // init released
        add(0,1,1,0,0,0,0, 0,0,0,0, 2, 0,0);   // IDLE
        add(0,0,1,0,0,0,0, 1,0,0,0, 2, 0,0);   // VC0 burst of 3
        add(0,0,1,0,0,0,0, 1,0,1,0, 3, 1,0);
        add(0,0,1,0,0,0,0, 1,0,1,0, 3, 2,0);
        add(0,1,1,0,0,0,0, 0,0,1,0, 3, 3,0);   // trailing pop_delay
        add(0,1,1,0,0,0,0, 0,0,0,0, 2, 3,0);
        add(0,0,0,0,0,0,0, 1,0,0,0, 2, 3,0);   // both busy: 0,0,0,0,1 x2
        add(0,0,0,0,0,0,0, 1,0,1,0, 3, 4,0);
        add(0,0,0,0,0,0,0, 1,0,1,0, 3, 5,0);
        add(0,0,0,0,0,0,0, 1,0,1,0, 3, 6,0);
        add(0,0,0,0,0,0,0, 0,1,1,0, 3, 7,0);
        add(0,0,0,0,0,0,0, 1,0,0,1, 3, 7,1);
        add(0,0,0,0,0,0,0, 1,0,1,0, 3, 8,1);
        add(0,0,0,0,0,0,0, 1,0,1,0, 3, 9,1);
        add(0,0,0,0,0,0,0, 1,0,1,0, 3,10,1);
        add(0,0,0,0,0,0,0, 0,1,1,0, 3,11,1);
        add(0,0,1,0,0,0,0, 1,0,0,1, 3,11,2);   // VC0 only
        add(0,0,1,0,1,0,0, 0,0,1,0, 3,12,2);   // D1 almost full: stop now
        add(0,0,1,0,1,0,0, 0,0,0,0, 3,12,2);
        add(0,0,1,1,0,0,0, 0,0,0,0, 3,12,2);   // D0 almost full also gates
        add(0,0,1,0,0,0,0, 1,0,0,0, 3,12,2);
        add(0,0,1,0,0,1,0, 1,0,1,0, 3,13,2);   // data arriving into full D0
        add(1,0,1,0,0,0,0, 0,0,0,0, 4,14,2);   // ERROR, init ignored
        add(1,0,1,0,0,0,0, 0,0,0,0, 4,14,2);
        add(0,0,0,0,0,0,0, 0,0,0,0, 4,14,2);

        #12;
        chk("reset_state", 0, 32'(state), 32'd0);
        chk("reset_pops", 0, {30'd0, pop_VC0, pop_VC1}, 32'd0);
        chk("reset_cnt", 0, {16'd0, cnt_VC0, cnt_VC1}, 32'd0);

        @(negedge clk);
        reset_L = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            init = tbl[i].init; VC0_empty = tbl[i].v0e; VC1_empty = tbl[i].v1e;
            D0_almost_full = tbl[i].af0; D1_almost_full = tbl[i].af1;
            D0_full = tbl[i].f0; D1_full = tbl[i].f1;
            #1;
            chk("pop_VC0", i, 32'(pop_VC0), 32'(tbl[i].p0));
            chk("pop_VC1", i, 32'(pop_VC1), 32'(tbl[i].p1));
            chk("pop_delay_VC0", i, 32'(pop_delay_VC0), 32'(tbl[i].pd0));
            chk("pop_delay_VC1", i, 32'(pop_delay_VC1), 32'(tbl[i].pd1));
            chk("state", i, 32'(state), 32'(tbl[i].st));
            chk("idle_out", i, 32'(idle_out), 32'(tbl[i].st == 3'd2));
            chk("error_out", i, 32'(error_out), 32'(tbl[i].st == 3'd4));
            chk("cnt_VC0", i, 32'(cnt_VC0), 32'(tbl[i].c0));
            chk("cnt_VC1", i, 32'(cnt_VC1), 32'(tbl[i].c1));
            @(negedge clk);
        end

        // Only reset leaves ERROR.
        reset_L = 1'b0;
        #1;
        chk("err_reset_state", 0, 32'(state), 32'd0);
        chk("err_reset_cnt", 0, 32'(cnt_VC0), 32'd0);
        init = 1'b1; VC0_empty = 1'b1; VC1_empty = 1'b1;
        D0_almost_full = 1'b0; D1_almost_full = 1'b0;
        D0_full = 1'b0; D1_full = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);                       // now INIT
        init = 1'b0;
        @(negedge clk);                       // now IDLE
        chk("seq_idle", 0, 32'(state), 32'd2);

        // Counter wrap: 255 pops, then one more.
        VC0_empty = 1'b0;
        repeat (255) @(negedge clk);
        chk("wrap_255", 0, 32'(cnt_VC0), 32'd255);
        @(negedge clk);
        chk("wrap_0", 0, 32'(cnt_VC0), 32'd0);
        chk("wrap_pd", 0, 32'(pop_delay_VC0), 32'd1);
        @(negedge clk);
        chk("cnt_after_wrap", 0, 32'(cnt_VC0), 32'd1);

        // init mid-burst: pop stops at once, counters clear in INIT.
        init = 1'b1;
        #1;
        chk("init_blocks_pop", 0, 32'(pop_VC0), 32'd0);
        @(negedge clk);
        chk("init_state", 0, 32'(state), 32'd1);
        @(negedge clk);
        chk("init_clears_cnt", 0, 32'(cnt_VC0), 32'd0);
        init = 1'b0;
        @(negedge clk);                       // IDLE, popping
        @(negedge clk);
        chk("burst_pd_before", 0, 32'(pop_delay_VC0), 32'd1);

        // Reset mid-cycle clears the in-flight qualifier without a clock edge.
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_pd0", 0, 32'(pop_delay_VC0), 32'd0);
        chk("async_pd1", 0, 32'(pop_delay_VC1), 32'd0);
        chk("async_state", 0, 32'(state), 32'd0);
        chk("async_pop", 0, 32'(pop_VC0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
